// File: rtl/mdio_arbiter.sv
// Two-port round-robin MDIO management arbiter: builds the 32-bit frame, launches it and returns the result.
// Optional transaction timeout (counter plus ERR_0/ERR_1) is built only when MDIO_ARB_TIMEOUT_EN is defined.
module mdio_arbiter #(
   parameter int TIMEOUT = 64
) (
   input  logic        MDC,
   input  logic        reset,
   input  logic        REQ_0,
   input  logic        REQ_1,
   input  logic        WR_0,
   input  logic        WR_1,
   input  logic [4:0]  PHY_ADDR_0,
   input  logic [4:0]  PHY_ADDR_1,
   input  logic [4:0]  REG_ADDR_0,
   input  logic [4:0]  REG_ADDR_1,
   input  logic [15:0] WDATA_0,
   input  logic [15:0] WDATA_1,
   output logic        ACK_0,
   output logic        ACK_1,
   output logic        ERR_0,
   output logic        ERR_1,
   output logic [15:0] RDATA,
   output logic        BUSY,
   output logic        TX_START,
   output logic [31:0] TX_FRAME,
   input  logic        TX_DONE,
   input  logic [15:0] TX_RD_DATA,
   output logic [1:0]  DBG_STATE
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_WAIT   = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        last_q, last_d;
   logic        sel_q, sel_d;
   logic        wr_q, wr_d;
   logic        ack0_q, ack0_d;
   logic        ack1_q, ack1_d;
   logic [15:0] rdata_q, rdata_d;
   logic        tx_start_q, tx_start_d;
   logic [31:0] tx_frame_q, tx_frame_d;
   logic        any_req;
   logic        grant;
   logic        timeout_hit;

   // Handshake: a client holds REQ_x (and its WR/address/data) until its one-cycle ACK_x;
   // the transmitter gets a one-cycle TX_START and answers with a one-cycle TX_DONE.
   assign any_req = REQ_0 | REQ_1;
   assign grant   = (REQ_0 & REQ_1) ? ~last_q : REQ_1;

   function automatic logic [31:0] build_frame(input logic        wr,
                                               input logic [4:0]  phy,
                                               input logic [4:0]  regad,
                                               input logic [15:0] wdata);
      return {2'b01, (wr ? 2'b01 : 2'b10), phy, regad, (wr ? 2'b10 : 2'b00),
              (wr ? wdata : 16'h0000)};
   endfunction

`ifdef MDIO_ARB_TIMEOUT_EN
   logic [7:0] cnt_q, cnt_d;
   logic       err0_q, err0_d;
   logic       err1_q, err1_d;

   assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

   always_comb begin
      cnt_d  = cnt_q;
      err0_d = 1'b0;
      err1_d = 1'b0;
      if (state_q == S_LAUNCH) begin
         cnt_d = '0;
      end else if (state_q == S_WAIT) begin
         cnt_d = cnt_q + 8'd1;
         // A TX_DONE arriving on the timeout cycle still counts as success.
         if (!TX_DONE && timeout_hit) begin
            err0_d = ~sel_q;
            err1_d = sel_q;
         end
      end
   end

   always_ff @(posedge MDC or negedge reset) begin
      if (!reset) begin
         cnt_q  <= '0;
         err0_q <= 1'b0;
         err1_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         err0_q <= err0_d;
         err1_q <= err1_d;
      end
   end

   assign ERR_0 = err0_q;
   assign ERR_1 = err1_q;
`else
   logic [7:0] unused_timeout;
   assign unused_timeout = 8'(TIMEOUT);
   assign timeout_hit    = 1'b0;
   assign ERR_0          = 1'b0;
   assign ERR_1          = 1'b0;
`endif

   always_ff @(posedge MDC or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         last_q     <= 1'b1;
         sel_q      <= 1'b0;
         wr_q       <= 1'b0;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         rdata_q    <= '0;
         tx_start_q <= 1'b0;
         tx_frame_q <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         sel_q      <= sel_d;
         wr_q       <= wr_d;
         ack0_q     <= ack0_d;
         ack1_q     <= ack1_d;
         rdata_q    <= rdata_d;
         tx_start_q <= tx_start_d;
         tx_frame_q <= tx_frame_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (any_req) state_d = S_LAUNCH;
         S_LAUNCH: state_d = S_WAIT;
         S_WAIT:   if (TX_DONE || timeout_hit) state_d = S_RESP;
         S_RESP:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      last_d     = last_q;
      sel_d      = sel_q;
      wr_d       = wr_q;
      ack0_d     = 1'b0;
      ack1_d     = 1'b0;
      rdata_d    = rdata_q;
      tx_start_d = 1'b0;
      tx_frame_d = tx_frame_q;
      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               sel_d      = grant;
               wr_d       = grant ? WR_1 : WR_0;
               tx_start_d = 1'b1;
               tx_frame_d = grant ? build_frame(WR_1, PHY_ADDR_1, REG_ADDR_1, WDATA_1)
                                  : build_frame(WR_0, PHY_ADDR_0, REG_ADDR_0, WDATA_0);
            end
         end
         S_WAIT: begin
            if (TX_DONE || timeout_hit) begin
               ack0_d  = ~sel_q;
               ack1_d  = sel_q;
               last_d  = sel_q;
               rdata_d = TX_DONE ? (wr_q ? 16'h0000 : TX_RD_DATA) : 16'hFFFF;
            end
         end
         default: ;
      endcase
   end

   assign ACK_0     = ack0_q;
   assign ACK_1     = ack1_q;
   assign RDATA     = rdata_q;
   assign BUSY      = (state_q != S_IDLE);
   assign TX_START  = tx_start_q;
   assign TX_FRAME  = tx_frame_q;
   assign DBG_STATE = state_q;

endmodule

// File: tb/tb_mdio_arbiter.sv
// Directed self-checking bench for mdio_arbiter; timeout scenarios run when MDIO_ARB_TIMEOUT_EN is defined.
module tb_mdio_arbiter;

   logic        MDC = 1'b0;
   logic        reset;
   logic        REQ_0, REQ_1, WR_0, WR_1;
   logic [4:0]  PHY_ADDR_0, PHY_ADDR_1, REG_ADDR_0, REG_ADDR_1;
   logic [15:0] WDATA_0, WDATA_1;
   logic        ACK_0, ACK_1, ERR_0, ERR_1;
   logic [15:0] RDATA;
   logic        BUSY, TX_START;
   logic [31:0] TX_FRAME;
   logic        TX_DONE;
   logic [15:0] TX_RD_DATA;
   logic [1:0]  DBG_STATE;

   int tests_run = 0;
   int tests_failed = 0;

   mdio_arbiter #(.TIMEOUT(64)) dut (
      .MDC(MDC), .reset(reset),
      .REQ_0(REQ_0), .REQ_1(REQ_1), .WR_0(WR_0), .WR_1(WR_1),
      .PHY_ADDR_0(PHY_ADDR_0), .PHY_ADDR_1(PHY_ADDR_1),
      .REG_ADDR_0(REG_ADDR_0), .REG_ADDR_1(REG_ADDR_1),
      .WDATA_0(WDATA_0), .WDATA_1(WDATA_1),
      .ACK_0(ACK_0), .ACK_1(ACK_1), .ERR_0(ERR_0), .ERR_1(ERR_1),
      .RDATA(RDATA), .BUSY(BUSY), .TX_START(TX_START), .TX_FRAME(TX_FRAME),
      .TX_DONE(TX_DONE), .TX_RD_DATA(TX_RD_DATA), .DBG_STATE(DBG_STATE)
   );

   // ---------------- clock / reset ----------------
   always #5 MDC = ~MDC;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
      $fatal(1);
   end

   task automatic tick();
      @(posedge MDC);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0;
      REQ_0 = 0; REQ_1 = 0; WR_0 = 0; WR_1 = 0;
      PHY_ADDR_0 = 0; PHY_ADDR_1 = 0; REG_ADDR_0 = 0; REG_ADDR_1 = 0;
      WDATA_0 = 0; WDATA_1 = 0; TX_DONE = 0; TX_RD_DATA = 16'hDEAD;
      tick(); tick();
      tests_run++;
      if ({ACK_0, ACK_1, ERR_0, ERR_1, TX_START, BUSY} !== 6'b0) begin
         tests_failed++;
         $display("FAIL reset_ctrl: got %b expected 000000", {ACK_0, ACK_1, ERR_0, ERR_1, TX_START, BUSY});
      end
      tests_run++;
      if (TX_FRAME !== 32'h0 || RDATA !== 16'h0) begin
         tests_failed++;
         $display("FAIL reset_data: got frame %h rdata %h expected 0 0", TX_FRAME, RDATA);
      end
      tests_run++;
      if (DBG_STATE !== 2'd0) begin
         tests_failed++;
         $display("FAIL reset_state: got %0d expected 0", DBG_STATE);
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_write_p0();
      bit saw_wrong;
      saw_wrong = 0;
      PHY_ADDR_0 = 5'h01; REG_ADDR_0 = 5'h04; WDATA_0 = 16'hA5A5; WR_0 = 1; REQ_0 = 1;
      tick();
      tests_run++;
      if (TX_START !== 1'b1 || TX_FRAME !== 32'h5092_A5A5 || BUSY !== 1'b1) begin
         tests_failed++;
         $display("FAIL write_launch: got start %b frame %h busy %b expected 1 5092a5a5 1", TX_START, TX_FRAME, BUSY);
      end
      tick();
      tests_run++;
      if (TX_START !== 1'b0 || DBG_STATE !== 2'd2) begin
         tests_failed++;
         $display("FAIL write_enter_wait: got start %b state %0d expected 0 2", TX_START, DBG_STATE);
      end
      for (int i = 0; i < 31; i++) begin
         tick();
         if (ACK_0 || ACK_1 || TX_START) saw_wrong = 1;
      end
      TX_DONE = 1;
      tick();
      TX_DONE = 0;
      if (ACK_1) saw_wrong = 1;
      tests_run++;
      if (ACK_0 !== 1'b1 || ERR_0 !== 1'b0) begin
         tests_failed++;
         $display("FAIL write_ack: got ack0 %b err0 %b expected 1 0", ACK_0, ERR_0);
      end
      tests_run++;
      if (TX_FRAME !== 32'h5092_A5A5 || RDATA !== 16'h0000) begin
         tests_failed++;
         $display("FAIL write_hold: got frame %h rdata %h expected 5092a5a5 0000", TX_FRAME, RDATA);
      end
      REQ_0 = 0;
      tick();
      if (ACK_1) saw_wrong = 1;
      tests_run++;
      if (ACK_0 !== 1'b0 || BUSY !== 1'b0) begin
         tests_failed++;
         $display("FAIL write_resp: got ack0 %b busy %b expected 0 0", ACK_0, BUSY);
      end
      tests_run++;
      if (saw_wrong !== 1'b0) begin
         tests_failed++;
         $display("FAIL write_spurious: got %b expected 0", saw_wrong);
      end
   endtask

   task automatic test_read_p1();
      TX_DONE = 1;
      tick();
      TX_DONE = 0;
      tests_run++;
      if (ACK_0 !== 1'b0 || ACK_1 !== 1'b0 || BUSY !== 1'b0) begin
         tests_failed++;
         $display("FAIL idle_done_ignored: got ack %b%b busy %b expected 00 0", ACK_1, ACK_0, BUSY);
      end
      PHY_ADDR_1 = 5'h03; REG_ADDR_1 = 5'h02; WDATA_1 = 16'hBEEF; WR_1 = 0; REQ_1 = 1;
      tick();
      tests_run++;
      if (TX_START !== 1'b1 || TX_FRAME !== 32'h6188_0000) begin
         tests_failed++;
         $display("FAIL read_launch: got start %b frame %h expected 1 61880000", TX_START, TX_FRAME);
      end
      tick();
      TX_DONE = 1; TX_RD_DATA = 16'h1234;
      tick();
      TX_DONE = 0; TX_RD_DATA = 16'hDEAD;
      tests_run++;
      if (ACK_1 !== 1'b1 || ACK_0 !== 1'b0 || ERR_1 !== 1'b0 || RDATA !== 16'h1234) begin
         tests_failed++;
         $display("FAIL read_ack: got ack %b%b err1 %b rdata %h expected 10 0 1234", ACK_1, ACK_0, ERR_1, RDATA);
      end
      REQ_1 = 0;
      tick();
      tests_run++;
      if (ACK_1 !== 1'b0 || BUSY !== 1'b0 || RDATA !== 16'h1234) begin
         tests_failed++;
         $display("FAIL read_resp: got ack1 %b busy %b rdata %h expected 0 0 1234", ACK_1, BUSY, RDATA);
      end
   endtask

   task automatic test_round_robin();
      logic [31:0] exp_frame;
      logic [1:0]  exp_ack;
      reset = 0;
      PHY_ADDR_0 = 5'h0A; REG_ADDR_0 = 5'h01; WDATA_0 = 16'h0000; WR_0 = 1;
      PHY_ADDR_1 = 5'h15; REG_ADDR_1 = 5'h1F; WDATA_1 = 16'h1111; WR_1 = 1;
      REQ_0 = 1; REQ_1 = 1;
      tick();
      reset = 1;
      for (int k = 0; k < 4; k++) begin
         exp_frame = (k % 2 == 0) ? 32'h5506_0000 : 32'h5AFE_1111;
         exp_ack   = (k % 2 == 0) ? 2'b01 : 2'b10;
         tick();
         tests_run++;
         if (TX_START !== 1'b1 || TX_FRAME !== exp_frame) begin
            tests_failed++;
            $display("FAIL rr_grant_%0d: got start %b frame %h expected 1 %h", k, TX_START, TX_FRAME, exp_frame);
         end
         tick();
         for (int i = 0; i < k; i++) tick();
         TX_DONE = 1;
         tick();
         TX_DONE = 0;
         tests_run++;
         if ({ACK_1, ACK_0} !== exp_ack) begin
            tests_failed++;
            $display("FAIL rr_ack_%0d: got %b expected %b", k, {ACK_1, ACK_0}, exp_ack);
         end
         tick();
         tests_run++;
         if ({ACK_1, ACK_0, BUSY} !== 3'b000) begin
            tests_failed++;
            $display("FAIL rr_resp_%0d: got ack %b%b busy %b expected 00 0", k, ACK_1, ACK_0, BUSY);
         end
      end
      REQ_0 = 0; REQ_1 = 0;
      tick();
   endtask

   task automatic test_reset_mid_wait();
      // Leave LAST pointing at port 0 so a surviving pointer would favour port 1.
      PHY_ADDR_0 = 5'h01; REG_ADDR_0 = 5'h04; WR_0 = 0; REQ_0 = 1;
      PHY_ADDR_1 = 5'h03; REG_ADDR_1 = 5'h02; WR_1 = 0;
      tick(); tick();
      TX_DONE = 1;
      tick();
      TX_DONE = 0; REQ_0 = 0;
      tick();
      REQ_1 = 1;
      tick(); tick(); tick(); tick();
      REQ_0 = 1;
      #3 reset = 0;
      #1;
      tests_run++;
      if ({BUSY, TX_START, ACK_0, ACK_1} !== 4'b0 || DBG_STATE !== 2'd0) begin
         tests_failed++;
         $display("FAIL reset_mid_ctrl: got %b state %0d expected 0000 0", {BUSY, TX_START, ACK_0, ACK_1}, DBG_STATE);
      end
      tests_run++;
      if (TX_FRAME !== 32'h0 || RDATA !== 16'h0) begin
         tests_failed++;
         $display("FAIL reset_mid_data: got frame %h rdata %h expected 0 0", TX_FRAME, RDATA);
      end
      tick();
      reset = 1;
      tick();
      tests_run++;
      if (TX_START !== 1'b1 || TX_FRAME !== 32'h6090_0000) begin
         tests_failed++;
         $display("FAIL reset_first_grant: got start %b frame %h expected 1 60900000", TX_START, TX_FRAME);
      end
      REQ_0 = 0; REQ_1 = 0;
      reset = 0;
      tick();
      reset = 1;
      tick();
   endtask

`ifdef MDIO_ARB_TIMEOUT_EN
   task automatic test_timeout();
      bit saw_early;
      saw_early = 0;
      WR_0 = 0; REQ_0 = 1;
      tick(); tick();
      for (int i = 0; i < 63; i++) begin
         tick();
         if (ACK_0 || ACK_1) saw_early = 1;
      end
      tick();
      tests_run++;
      if (ACK_0 !== 1'b1 || ERR_0 !== 1'b1 || RDATA !== 16'hFFFF || ACK_1 !== 1'b0 || saw_early !== 1'b0) begin
         tests_failed++;
         $display("FAIL timeout_abort: got ack %b%b err0 %b rdata %h early %b expected 01 1 ffff 0", ACK_1, ACK_0, ERR_0, RDATA, saw_early);
      end
      REQ_0 = 0; TX_DONE = 1; TX_RD_DATA = 16'h7777;
      tick();
      tests_run++;
      if (ACK_0 !== 1'b0 || ERR_0 !== 1'b0 || BUSY !== 1'b0) begin
         tests_failed++;
         $display("FAIL timeout_resp: got ack0 %b err0 %b busy %b expected 0 0 0", ACK_0, ERR_0, BUSY);
      end
      tick();
      TX_DONE = 0; TX_RD_DATA = 16'hDEAD;
      tests_run++;
      if (ACK_0 !== 1'b0 || BUSY !== 1'b0 || RDATA !== 16'hFFFF) begin
         tests_failed++;
         $display("FAIL timeout_late_done: got ack0 %b busy %b rdata %h expected 0 0 ffff", ACK_0, BUSY, RDATA);
      end
   endtask

   task automatic test_done_and_timeout();
      WR_1 = 0; REQ_1 = 1;
      tick(); tick();
      for (int i = 0; i < 63; i++) tick();
      TX_DONE = 1; TX_RD_DATA = 16'h5A5A;
      tick();
      TX_DONE = 0; TX_RD_DATA = 16'hDEAD;
      tests_run++;
      if (ACK_1 !== 1'b1 || ERR_1 !== 1'b0 || RDATA !== 16'h5A5A) begin
         tests_failed++;
         $display("FAIL done_vs_timeout: got ack1 %b err1 %b rdata %h expected 1 0 5a5a", ACK_1, ERR_1, RDATA);
      end
      REQ_1 = 0;
      tick();
      tests_run++;
      if (BUSY !== 1'b0) begin
         tests_failed++;
         $display("FAIL done_vs_timeout_idle: got busy %b expected 0", BUSY);
      end
   endtask
`else
   task automatic test_no_timeout();
      bit saw_ack;
      saw_ack = 0;
      WR_0 = 0; REQ_0 = 1;
      tick(); tick();
      for (int i = 0; i < 80; i++) begin
         tick();
         if (ACK_0 || ACK_1) saw_ack = 1;
      end
      tests_run++;
      if (saw_ack !== 1'b0 || BUSY !== 1'b1) begin
         tests_failed++;
         $display("FAIL unbounded_wait: got ack %b busy %b expected 0 1", saw_ack, BUSY);
      end
      TX_DONE = 1; TX_RD_DATA = 16'hC3C3;
      tick();
      TX_DONE = 0; TX_RD_DATA = 16'hDEAD;
      tests_run++;
      if (ACK_0 !== 1'b1 || ERR_0 !== 1'b0 || RDATA !== 16'hC3C3) begin
         tests_failed++;
         $display("FAIL unbounded_done: got ack0 %b err0 %b rdata %h expected 1 0 c3c3", ACK_0, ERR_0, RDATA);
      end
      REQ_0 = 0;
      tick();
   endtask
`endif

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_write_p0();
      test_read_p1();
      test_round_robin();
      test_reset_mid_wait();
`ifdef MDIO_ARB_TIMEOUT_EN
      test_timeout();
      test_done_and_timeout();
`else
      test_no_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
